ofm_requant_drain: RTL

Downstream drain stage for the 3x3 convolution kernel. It captures the per-column partial-sum stream (`sum`/`sum_valid`, one lane per PE-array column), buffers each lane in its own FIFO, and arbitrates the lanes round-robin into a single requantize pipeline (multiply, rounding shift, zero-point, int8 clamp). Results leave on a valid/ready stream tagged with column index and tile-line end. The kernel has no backpressure input, so lane overflow is flagged, never stalled.

---
 rtl/ofm_requant_drain_if.sv | 21 ++
 rtl/ofm_requant_drain.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ofm_requant_drain_if.sv
// Output beat stream of the OFM requantize drain.
//   out_valid : beat valid (master -> slave)
//   out_ready : consumer accepts beat (slave -> master)
//   out_data  : requantized signed value
//   out_col   : source lane of the beat
//   out_last  : beat closes its lane's current tile line
interface ofm_requant_drain_if #(
  parameter int COL       = 4,
  parameter int OUT_WIDTH = 8
);
  logic                        out_valid;
  logic                        out_ready;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic [$clog2(COL)-1:0]      out_col;
  logic                        out_last;

  modport master (output out_valid, output out_data, output out_col, output out_last,
                  input  out_ready);
  modport slave  (input  out_valid, input  out_data, input  out_col, input  out_last,
                  output out_ready);
endinterface

// File: rtl/ofm_requant_drain.sv
// Drain stage for the 3x3 convolution kernel: buffers one partial-sum lane
// per PE-array column in its own FIFO, arbitrates non-empty lanes round-robin
// into a two-stage requantize pipeline (multiply, rounding shift, zero point,
// clamp) and emits beats on a valid/ready stream.
//   clk, rst      : clock, synchronous active-high reset
//   sum/sum_valid : per-lane signed sums and push strobes (no backpressure)
//   cfg_mult/shift/zp : requant parameters, stable while not idle
//   out_if        : output beat stream (valid/ready, data, col, last)
//   ovf           : sticky per-lane overflow (sum dropped on a full FIFO)
//   idle          : all FIFOs and pipeline stages empty
module ofm_requant_drain #(
  parameter int COL        = 4,
  parameter int OFM_WIDTH  = 32,
  parameter int TILE_LEN   = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [OFM_WIDTH-1:0] sum [COL],
  input  logic [COL-1:0]              sum_valid,
  input  logic [15:0]                 cfg_mult,
  input  logic [4:0]                  cfg_shift,
  input  logic signed [7:0]           cfg_zp,
  ofm_requant_drain_if.master         out_if,
  output logic [COL-1:0]              ovf,
  output logic                        idle
);

  localparam int CW = $clog2(COL);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(TILE_LEN);
  localparam int PW = OFM_WIDTH + 17;
  localparam logic signed [PW:0] SAT_MAX = (PW+1)'(2 ** (OUT_WIDTH - 1) - 1);
  localparam logic signed [PW:0] SAT_MIN = -SAT_MAX - (PW+1)'(1);

  // Round half up, then arithmetic shift; PW has headroom for the bias.
  function automatic logic signed [PW-1:0] round_shift(input logic signed [PW-1:0] p,
                                                       input logic [4:0] sh);
    logic signed [PW-1:0] r;
    r = p;
    if (sh != 5'd0) r = p + (PW'(1) << (sh - 5'd1));
    return r >>> sh;
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [PW:0] v);
    if (v > SAT_MAX) return SAT_MAX[OUT_WIDTH-1:0];
    if (v < SAT_MIN) return SAT_MIN[OUT_WIDTH-1:0];
    return v[OUT_WIDTH-1:0];
  endfunction

  logic signed [OFM_WIDTH-1:0] fifo_mem_q [COL][FIFO_DEPTH];
  logic [AW:0]    wr_q [COL], wr_d [COL], rd_q [COL], rd_d [COL];
  logic [LW-1:0]  line_q [COL], line_d [COL];
  logic [COL-1:0] empty, full, pop_lane, push_ok, ovf_q, ovf_d;
  logic [CW-1:0]  rr_q, rr_d, grant;
  logic           found, pop, en;

  logic signed [PW-1:0]        prod_p1_q, prod_p1_d;
  logic [CW-1:0]               col_p1_q, col_p1_d;
  logic                        last_p1_q, last_p1_d, vld_p1_q, vld_p1_d;
  logic signed [OUT_WIDTH-1:0] data_p2_q, data_p2_d;
  logic [CW-1:0]               col_p2_q, col_p2_d;
  logic                        last_p2_q, last_p2_d, vld_p2_q, vld_p2_d;
  logic signed [PW-1:0]        shifted;
  logic signed [PW:0]          biased;
  logic signed [OFM_WIDTH-1:0] sel_sum;

  // Full/empty use an extra wrap bit on each pointer.
  always_comb begin
    empty = '0;
    full  = '0;
    for (int c = 0; c < COL; c++) begin
      empty[c] = (wr_q[c] == rd_q[c]);
      full[c]  = (wr_q[c][AW] != rd_q[c][AW]) && (wr_q[c][AW-1:0] == rd_q[c][AW-1:0]);
    end
  end

  // Round-robin: search starts one past the last granted lane.
  always_comb begin : arb
    int idx;
    idx   = 0;
    grant = rr_q;
    found = 1'b0;
    for (int i = 1; i <= COL; i++) begin
      idx = (int'(rr_q) + i) % COL;
      if (!found && !empty[idx]) begin
        found = 1'b1;
        grant = CW'(idx);
      end
    end
  end

  assign en  = !vld_p2_q || out_if.out_ready;
  assign pop = found && en;

  always_comb begin
    pop_lane = '0;
    push_ok  = '0;
    ovf_d    = ovf_q;
    rr_d     = pop ? grant : rr_q;
    for (int c = 0; c < COL; c++) begin
      pop_lane[c] = pop && (grant == CW'(c));
      // A full lane still takes the push when it is drained this same cycle.
      push_ok[c]  = sum_valid[c] && (!full[c] || pop_lane[c]);
      ovf_d[c]    = ovf_q[c] | (sum_valid[c] & full[c] & ~pop_lane[c]);
      wr_d[c]     = wr_q[c] + (AW+1)'(push_ok[c]);
      rd_d[c]     = rd_q[c] + (AW+1)'(pop_lane[c]);
      line_d[c]   = line_q[c];
      if (pop_lane[c])
        line_d[c] = (line_q[c] == LW'(TILE_LEN - 1)) ? '0 : line_q[c] + LW'(1);
    end
  end

  // ---- P1: pop, multiply, tag with lane and line end ----
  always_comb begin
    sel_sum   = fifo_mem_q[grant][rd_q[grant][AW-1:0]];
    prod_p1_d = prod_p1_q;
    col_p1_d  = col_p1_q;
    last_p1_d = last_p1_q;
    vld_p1_d  = en ? pop : vld_p1_q;
    if (pop) begin
      prod_p1_d = PW'(sel_sum) * PW'($signed({1'b0, cfg_mult}));
      col_p1_d  = grant;
      last_p1_d = (line_q[grant] == LW'(TILE_LEN - 1));
    end
  end

  // ---- P2: round, shift, zero point, clamp ----
  always_comb begin
    shifted   = round_shift(prod_p1_q, cfg_shift);
    biased    = (PW+1)'(shifted) + (PW+1)'(cfg_zp);
    data_p2_d = data_p2_q;
    col_p2_d  = col_p2_q;
    last_p2_d = last_p2_q;
    vld_p2_d  = en ? vld_p1_q : vld_p2_q;
    if (en && vld_p1_q) begin
      data_p2_d = saturate(biased);
      col_p2_d  = col_p1_q;
      last_p2_d = last_p1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q      <= '{default: '0};
      rd_q      <= '{default: '0};
      line_q    <= '{default: '0};
      ovf_q     <= '0;
      rr_q      <= CW'(COL - 1);
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      data_p2_q <= '0;
      col_p2_q  <= '0;
      last_p2_q <= 1'b0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      line_q    <= line_d;
      ovf_q     <= ovf_d;
      rr_q      <= rr_d;
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      data_p2_q <= data_p2_d;
      col_p2_q  <= col_p2_d;
      last_p2_q <= last_p2_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < COL; c++)
      if (push_ok[c]) fifo_mem_q[c][wr_q[c][AW-1:0]] <= sum[c];
    prod_p1_q <= prod_p1_d;
    col_p1_q  <= col_p1_d;
    last_p1_q <= last_p1_d;
  end

  assign out_if.out_valid = vld_p2_q;
  assign out_if.out_data  = data_p2_q;
  assign out_if.out_col   = col_p2_q;
  assign out_if.out_last  = last_p2_q;
  assign ovf              = ovf_q;
  assign idle             = (&empty) && !vld_p1_q && !vld_p2_q;

endmodule
